// File: rtl/permutator_pkg.sv
// Shared definitions for the address-XOR permutation network and its inverse.
// Frame-length helper, index type and the index scrambling function.
package permutator_pkg;

  localparam int LOG2SLICES_MAX = 6;

  // Sized for the widest legal frame; users take the low LOG2SLICES bits.
  typedef logic [LOG2SLICES_MAX-1:0] idx_t;

  function automatic int num_slices(input int log2slices);
    return 1 << log2slices;
  endfunction

  function automatic idx_t xor_index(input idx_t idx, input idx_t key);
    return idx ^ key;
  endfunction

endpackage

// File: rtl/depermutator_bank.sv
// Ping-pong frame storage: two banks of N words.
// One synchronous write port and one asynchronous read port.
module depermutator_bank
  import permutator_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LOG2SLICES = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  wbank,
  input  logic [LOG2SLICES-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rbank,
  input  logic [LOG2SLICES-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int N = num_slices(LOG2SLICES);

  // No reset: contents are only ever read after being written by a full frame.
  logic [DATA_WIDTH-1:0] mem_q [2][N];

  always_ff @(posedge clk) begin
    if (we) mem_q[wbank][waddr] <= wdata;
  end

  assign rdata = mem_q[rbank][raddr];

endmodule

// File: rtl/depermutator_stream.sv
// Streaming inverse of the address-XOR permutation: buffers each permuted
// frame at index^cfg in a ping-pong store and replays it in natural order.
module depermutator_stream
  import permutator_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LOG2SLICES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LOG2SLICES-1:0] cfg,
  input  logic [DATA_WIDTH-1:0] t_dat,
  input  logic                  t_valid,
  output logic                  t_ready,
  output logic [DATA_WIDTH-1:0] i_dat,
  output logic                  i_valid,
  input  logic                  i_ready,
  output logic                  i_last,
  output logic                  busy
);

  localparam int N = num_slices(LOG2SLICES);
  typedef logic [LOG2SLICES-1:0] cnt_t;
  localparam cnt_t CNT_LAST = cnt_t'(N - 1);

  logic                  wbank_q, wbank_d;
  logic                  rbank_q, rbank_d;
  cnt_t                  wcnt_q, wcnt_d;
  cnt_t                  rcnt_q, rcnt_d;
  logic [1:0]            full_q, full_d;
  cnt_t                  cfg_lat_q, cfg_lat_d;
  logic [DATA_WIDTH-1:0] i_dat_q, i_dat_d;
  logic                  i_valid_q, i_valid_d;
  logic                  i_last_q, i_last_d;

  logic                  accept;
  logic                  load;
  cnt_t                  key;
  cnt_t                  waddr;
  idx_t                  waddr_wide;
  logic [DATA_WIDTH-1:0] rdata;

  depermutator_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .LOG2SLICES(LOG2SLICES)
  ) u_bank (
    .clk  (clk),
    .we   (accept),
    .wbank(wbank_q),
    .waddr(waddr),
    .wdata(t_dat),
    .rbank(rbank_q),
    .raddr(rcnt_q),
    .rdata(rdata)
  );

  // Gated by rst so upstream never sees an accept while state is being cleared.
  assign t_ready = !rst && !full_q[wbank_q];
  assign accept  = t_valid && t_ready;
  assign load    = full_q[rbank_q] && (!i_valid_q || i_ready);

  // Word 0 uses the live key so the frame's first word lands without a bubble.
  assign key        = (wcnt_q == '0) ? cfg : cfg_lat_q;
  assign waddr_wide = xor_index(idx_t'(wcnt_q), idx_t'(key));
  assign waddr      = waddr_wide[LOG2SLICES-1:0];

  always_comb begin
    wbank_d   = wbank_q;
    wcnt_d    = wcnt_q;
    cfg_lat_d = cfg_lat_q;
    full_d    = full_q;
    if (accept) begin
      if (wcnt_q == '0) cfg_lat_d = cfg;
      wcnt_d = wcnt_q + cnt_t'(1);
      if (wcnt_q == CNT_LAST) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = !wbank_q;
      end
    end
    // Release never targets the bank being completed: that one is not full yet.
    if (load && (rcnt_q == CNT_LAST)) full_d[rbank_q] = 1'b0;
  end

  always_comb begin
    rbank_d   = rbank_q;
    rcnt_d    = rcnt_q;
    i_dat_d   = i_dat_q;
    i_valid_d = i_valid_q;
    i_last_d  = i_last_q;
    if (load) begin
      i_dat_d   = rdata;
      i_last_d  = (rcnt_q == CNT_LAST);
      i_valid_d = 1'b1;
      rcnt_d    = rcnt_q + cnt_t'(1);
      if (rcnt_q == CNT_LAST) rbank_d = !rbank_q;
    end else if (i_ready) begin
      i_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbank_q   <= 1'b0;
      rbank_q   <= 1'b0;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      full_q    <= 2'b00;
      cfg_lat_q <= '0;
      i_dat_q   <= '0;
      i_valid_q <= 1'b0;
      i_last_q  <= 1'b0;
    end else begin
      wbank_q   <= wbank_d;
      rbank_q   <= rbank_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      full_q    <= full_d;
      cfg_lat_q <= cfg_lat_d;
      i_dat_q   <= i_dat_d;
      i_valid_q <= i_valid_d;
      i_last_q  <= i_last_d;
    end
  end

  assign i_dat   = i_dat_q;
  assign i_valid = i_valid_q;
  assign i_last  = i_last_q;
  assign busy    = (|full_q) || (wcnt_q != '0);

endmodule

// File: tb/tb_depermutator_stream.sv
// Scoreboard bench for depermutator_stream: a frame-level model predicts
// out[j] = in[j ^ cfg]; a separate monitor pops and compares every handshake.
module tb_depermutator_stream;

  localparam int DW = 32;
  localparam int L2 = 3;
  localparam int N  = 1 << L2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [L2-1:0] cfg = '0;
  logic [DW-1:0] t_dat = '0;
  logic          t_valid = 1'b0;
  logic          t_ready;
  logic [DW-1:0] i_dat;
  logic          i_valid;
  logic          i_ready = 1'b0;
  logic          i_last;
  logic          busy;

  depermutator_stream #(.DATA_WIDTH(DW), .LOG2SLICES(L2)) dut (
    .clk(clk), .rst(rst), .cfg(cfg), .t_dat(t_dat), .t_valid(t_valid),
    .t_ready(t_ready), .i_dat(i_dat), .i_valid(i_valid), .i_ready(i_ready),
    .i_last(i_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] fbuf[N];
  int            fcnt = 0;
  int            fcfg = 0;
  int            nvec = 0;
  int            nerr = 0;
  logic          acc_last;
  int            drv_edge;

  task automatic chk(input string name, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: collect a frame, then emit it in natural order.
  task automatic model_accept(input logic [DW-1:0] d, input logic [L2-1:0] c);
    exp_t e;
    if (fcnt == 0) fcfg = int'(c);
    fbuf[fcnt] = d;
    fcnt++;
    if (fcnt == N) begin
      for (int j = 0; j < N; j++) begin
        e.data = fbuf[j ^ fcfg];
        e.last = (j == N - 1);
        sb.push_back(e);
      end
      fcnt = 0;
    end
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d, input logic [L2-1:0] c,
                      input logic r);
    @(negedge clk);
    t_valid  = v;
    t_dat    = d;
    cfg      = c;
    i_ready  = r;
    drv_edge = cyc + 1;
    acc_last = v && t_ready;
    if (acc_last) model_accept(d, c);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || i_valid || busy) && n < 200) begin
      step(1'b0, '0, '0, 1'b1);
      n++;
    end
    chk("drain_timeout", n < 200, 1);
  endtask

  // Monitor: a handshake happens at the edge after this sample point.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && i_valid && i_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", i_dat, 0);
          nerr += (nvec > 0 && i_dat == 0) ? 1 : 0;
        end else begin
          e = sb.pop_front();
          chk("out_data", i_dat, e.data);
          chk("out_last", i_last, e.last);
        end
      end
    end
  end

  initial begin
    int a, n, acc;
    logic [L2-1:0] fc;

    // Reset state
    #1;
    chk("rst_t_ready", t_ready, 0);
    chk("rst_i_valid", i_valid, 0);
    chk("rst_i_dat", i_dat, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_t_ready", t_ready, 1);

    // Directed frame, cfg=101, plus first-output latency
    for (int w = 0; w < N; w++) begin
      step(1'b1, 32'hD000 + w, 3'b101, 1'b1);
      if (w == 0) a = drv_edge;
    end
    n = 0;
    do begin
      step(1'b0, '0, '0, 1'b1);
      n++;
    end while (!i_valid && n < 20);
    chk("latency", cyc - a, N);
    drain();

    // Four identity frames at full rate: no t_ready or i_valid gaps
    for (int w = 0; w < 4 * N; w++) begin
      step(1'b1, $urandom, 3'b000, 1'b1);
      chk("full_rate_t_ready", acc_last, 1);
      if (w >= N + 1) chk("full_rate_i_valid", i_valid, 1);
    end
    drain();

    // cfg changes mid-frame are ignored: frame reversed
    for (int w = 0; w < N; w++)
      step(1'b1, 32'hC000 + w, (w < 3) ? 3'b111 : 3'b010, 1'b1);
    drain();

    // Backpressure: both banks fill, output holds
    acc = 0;
    for (int w = 0; w < 20; w++) begin
      step(1'b1, $urandom, 3'($urandom), 1'b0);
      if (acc_last) acc++;
      if (w >= 12) begin
        chk("hold_valid", i_valid, 1);
        chk("hold_data", i_dat, sb[0].data);
        chk("hold_last", i_last, 0);
      end
    end
    chk("bp_accepted", acc, 2 * N);
    chk("bp_t_ready", t_ready, 0);
    drain();

    // Reset mid-frame after a buffered frame and 5 words of the next
    for (int w = 0; w < N + 5; w++) step(1'b1, $urandom, 3'b011, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    t_valid = 1'b0;
    #1;
    chk("mid_rst_i_valid", i_valid, 0);
    chk("mid_rst_i_dat", i_dat, 0);
    chk("mid_rst_i_last", i_last, 0);
    chk("mid_rst_t_ready", t_ready, 0);
    chk("mid_rst_busy", busy, 0);
    sb.delete();
    fcnt = 0;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_t_ready", t_ready, 1);
    for (int w = 0; w < N; w++) step(1'b1, 32'hE000 + w, 3'b110, 1'b1);
    drain();

    // Random traffic, random cfg per frame
    fc = 3'($urandom);
    for (int f = 0; f < 200; ) begin
      step(1'($urandom_range(0, 1)), $urandom, fc, 1'($urandom_range(0, 1)));
      if (acc_last && fcnt == 0) begin
        f++;
        fc = 3'($urandom);
      end else if (acc_last && fcnt == 1) begin
        fc = 3'($urandom);
      end
    end
    step(1'b0, '0, '0, 1'b1);
    drain();
    chk("final_queue_empty", sb.size(), 0);
    chk("final_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
